// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return !op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation: abs() on the way in, sign correction on the way out.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output state_e           state_dbg
);

  // Handshake: start is accepted only when busy=0 (state IDLE); busy stays high
  // until the result is written, and done pulses for one cycle as HI/LO change.

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               div0;
  logic [WIDTH-1:0]   mag;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               op_signed;

  assign op_signed = op_is_signed(op);
  assign state_dbg = state;

  muldiv_signfix #(.W(WIDTH)) u_abs_a (.x(a), .neg(op_signed & a[WIDTH-1]), .y(abs_a));
  muldiv_signfix #(.W(WIDTH)) u_abs_b (.x(b), .neg(op_signed & b[WIDTH-1]), .y(abs_b));

  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (.x(acc), .neg(neg_lo), .y(prod_fix));
  muldiv_signfix #(.W(WIDTH)) u_fix_quot (.x(acc[WIDTH-1:0]), .neg(neg_lo), .y(quot_fix));
  muldiv_signfix #(.W(WIDTH)) u_fix_rem (.x(acc[2*WIDTH-1:WIDTH]), .neg(neg_hi), .y(rem_fix));

  // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
  // Divide: acc = {remainder, dividend/quotient}; quotient bits enter at the bottom.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_hi;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] step_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
    div_hi    = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_hi >= {1'b0, mag});
    div_rem   = div_ge ? (div_hi[WIDTH-1:0] - mag) : div_hi[WIDTH-1:0];
    step_next = is_div ? {div_rem, acc[WIDTH-2:0], div_ge}
                       : {mul_sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
      mag    <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div <= op_is_div(op);
            neg_lo <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi <= op_signed & a[WIDTH-1];
            div0   <= (b == '0);
            mag    <= op_is_div(op) ? abs_b : abs_a;
            acc    <= {{WIDTH{1'b0}}, (op_is_div(op) ? abs_a : abs_b)};
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_CALC;
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        S_CALC: begin
          acc <= step_next;
          if (cnt == CNT_LAST) state <= S_FIX;
          else cnt <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          if (is_div) begin
            // Divide by zero: remainder already equals the dividend; force LO to all ones.
            lo <= div0 ? '1 : quot_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences, random ops vs. model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;
  state_e      state_dbg;

  int n_vec;
  int n_err;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .state_dbg(state_dbg)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain wide arithmetic, truncating signed division.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rh, output logic [31:0] rl);
    longint sx, sy, p;
    logic [63:0] pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin p = sx * sy; {rh, rl} = p; end
      2'b01: begin pu = {32'b0, x} * {32'b0, y}; {rh, rl} = pu; end
      2'b10: if (y == 0) begin rh = x; rl = '1; end
             else begin rl = 32'(sx / sy); rh = 32'(sx % sy); end
      default: if (y == 0) begin rh = x; rl = '1; end
               else begin rl = x / y; rh = x % y; end
    endcase
  endfunction

  // driver tasks
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Counts edges since E0 until done is seen; busy must hold high until then.
  task automatic wait_done(input int lat0, output int lat, output bit busy_ok);
    bit seen;
    lat = lat0;
    busy_ok = 1'b1;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        seen = 1'b1;
        if (busy) busy_ok = 1'b0;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic exec_check(input string name, input logic [1:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    bit busy_ok;
    launch(o, x, y);
    wait_done(0, lat, busy_ok);
    check({name, " latency"}, 32'(lat), 32'd33);
    check({name, " busy"}, 32'(busy_ok), 32'd1);
    check({name, " hi"}, hi, ehi);
    check({name, " lo"}, lo, elo);
    @(posedge clk);
    #1;
    check({name, " done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] rh, rl, x, y, hold;
    logic [1:0]  o;
    int lat, cnt;
    bit busy_ok;

    n_vec = 0;
    n_err = 0;
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;

    vecs.push_back('{"multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"mult_neg",   OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB});
    vecs.push_back('{"div_neg",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"divu_basic", OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14});
    vecs.push_back('{"divu_zero",  OP_DIVU,  32'h64,       32'd0,        32'h64,       32'hFFFFFFFF});
    vecs.push_back('{"div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000});
    vecs.push_back('{"div_zero_s", OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF});
    vecs.push_back('{"mult_min",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0});
    vecs.push_back('{"div_negb",   OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
    vecs.push_back('{"multu_zero", OP_MULTU, 32'd0,        32'hDEADBEEF, 32'd0,        32'd0});
    vecs.push_back('{"divu_one",   OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF});
    vecs.push_back('{"divu_small", OP_DIVU,  32'd5,        32'd9,        32'd5,        32'd0});
    vecs.push_back('{"mult_m1m1",  OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1});

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst state", 32'(state_dbg), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b1;

    // MTHI, MTLO, both together
    @(negedge clk); a = 32'h12345678; mthi = 1'b1;
    @(posedge clk); #1; mthi = 1'b0;
    check("mthi hi", hi, 32'h12345678);
    check("mthi lo", lo, 32'd0);
    @(negedge clk); a = 32'hCAFEF00D; mtlo = 1'b1;
    @(posedge clk); #1; mtlo = 1'b0;
    check("mtlo lo", lo, 32'hCAFEF00D);
    check("mtlo hi", hi, 32'h12345678);
    @(negedge clk); a = 32'hA5A5A5A5; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    check("mtboth hi", hi, 32'hA5A5A5A5);
    check("mtboth lo", lo, 32'hA5A5A5A5);

    // start and mthi in the same idle cycle: move dropped
    @(negedge clk); op = OP_MULTU; a = 32'd5; b = 32'd6; start = 1'b1; mthi = 1'b1;
    @(posedge clk); #1; start = 1'b0; mthi = 1'b0;
    check("start_vs_mthi hi", hi, 32'hA5A5A5A5);
    wait_done(0, lat, busy_ok);
    check("start_vs_mthi lat", 32'(lat), 32'd33);
    check("start_vs_mthi res_hi", hi, 32'd0);
    check("start_vs_mthi res_lo", lo, 32'd30);

    // directed table
    for (int i = 0; i < vecs.size(); i++)
      exec_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);

    // start and mtlo while busy are ignored
    hold = lo;
    launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) @(posedge clk);
    #1;
    op = OP_DIV; a = 32'h0000DEAD; b = 32'd3; start = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    check("busy_mtlo lo", lo, hold);
    wait_done(5, lat, busy_ok);
    check("busy_start lat", 32'(lat), 32'd33);
    check("busy_start busy", 32'(busy_ok), 32'd1);
    check("busy_start hi", hi, 32'hFFFFFFFE);
    check("busy_start lo", lo, 32'h00000001);

    // random ops against the model
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 4) == 0) y = ~y;
      model(o, x, y, rh, rl);
      exec_check($sformatf("rand%0d op%0d %h/%h", i, o, x, y), o, x, y, rh, rl);
    end

    // asynchronous reset in the middle of an operation
    launch(OP_MULTU, 32'h12345678, 32'h9ABCDEF0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    check("midrst done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check("midrst no_done", 32'(cnt), 32'd0);
    model(OP_DIV, 32'hFFFF0000, 32'd12345, rh, rl);
    exec_check("after_rst", OP_DIV, 32'hFFFF0000, 32'd12345, rh, rl);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
